// File: rtl/key_event_fifo.sv
// Memory-mapped key input port: synchronises key levels, queues a snapshot on every
// unmasked change, and exposes DATA/CTRL/MASK registers plus a level interrupt.
module key_event_fifo #(
  parameter int              NUM_KEYS  = 4,
  parameter int              BITS      = 32,
  parameter int              DEPTH     = 8,
  parameter logic [BITS-1:0] BASE      = 32'hF0000010,
  parameter logic [BITS-1:0] CTRL_BASE = 32'hF0000110,
  parameter logic [BITS-1:0] MASK_BASE = 32'hF0000210
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic                re,
  input  logic [BITS-1:0]     memAddr,
  input  logic [BITS-1:0]     dataBusIn,
  input  logic [NUM_KEYS-1:0] key,
  output logic [BITS-1:0]     dataBusOut,
  output logic                irq
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [NUM_KEYS-1:0] keyMeta_r, keySync_r, keyPrev_r, mask_r;
  logic [NUM_KEYS-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]    wptr_r, rptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                overrun_r, ie_r;

  logic rdData_s, rdCtrl_s, rdMask_s, wrCtrl_s, wrMask_s;
  logic evt_s, push_s, pop_s, overflow_s, notEmpty_s;
  logic unusedBus_s;

  assign rdData_s = re & ~we & (memAddr == BASE);
  assign rdCtrl_s = re & ~we & (memAddr == CTRL_BASE);
  assign rdMask_s = re & ~we & (memAddr == MASK_BASE);
  assign wrCtrl_s = we & (memAddr == CTRL_BASE);
  assign wrMask_s = we & (memAddr == MASK_BASE);

  assign notEmpty_s  = (count_r != '0);
  assign evt_s       = |((keySync_r ^ keyPrev_r) & mask_r);
  assign pop_s       = rdData_s & notEmpty_s;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_s      = evt_s & ((count_r < FULL_CNT) | pop_s);
  assign overflow_s  = evt_s & ~push_s;
  assign unusedBus_s = ^dataBusIn;

  assign irq = ie_r & (notEmpty_s | overrun_r);

  // Key synchroniser and change-detect snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keyMeta_r <= '0;
      keySync_r <= '0;
      keyPrev_r <= '0;
    end else begin
      keyMeta_r <= key;
      keySync_r <= keyMeta_r;
      keyPrev_r <= keySync_r;
    end
  end

  // Event storage; head is only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= keySync_r;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) wptr_r <= wptr_r + PTR_ONE;
      if (pop_s)  rptr_r <= rptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Control and mask registers; a coincident overflow beats a clearing write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_r <= 1'b0;
      ie_r      <= 1'b0;
      mask_r    <= '1;
    end else begin
      if (overflow_s)                      overrun_r <= 1'b1;
      else if (wrCtrl_s && !dataBusIn[2])  overrun_r <= 1'b0;
      if (wrCtrl_s) ie_r   <= dataBusIn[8];
      if (wrMask_s) mask_r <= dataBusIn[NUM_KEYS-1:0];
    end
  end

  // Read-data mux.
  always_comb begin
    dataBusOut = '0;
    if (!reset) begin
      dataBusOut = '0;
    end else if (rdData_s) begin
      if (notEmpty_s) begin
        dataBusOut[NUM_KEYS-1:0] = mem_r[rptr_r];
      end else begin
        dataBusOut = '0;
      end
    end else if (rdCtrl_s) begin
      dataBusOut[0]            = notEmpty_s;
      dataBusOut[2]            = overrun_r;
      dataBusOut[8]            = ie_r;
      dataBusOut[16 +: CNT_W]  = count_r;
    end else if (rdMask_s) begin
      dataBusOut[NUM_KEYS-1:0] = mask_r;
    end else begin
      dataBusOut = '0;
    end
  end

endmodule

// File: tb/tb_key_event_fifo.sv
// Scoreboard bench for key_event_fifo: reads push expected data/irq into a queue,
// a negedge monitor pops and compares whenever a bus read is presented.
module tb_key_event_fifo;

  localparam logic [31:0] A_DATA = 32'hF0000010;
  localparam logic [31:0] A_CTRL = 32'hF0000110;
  localparam logic [31:0] A_MASK = 32'hF0000210;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] memAddr = 32'h0;
  logic [31:0] dataBusIn = 32'h0;
  logic [3:0]  key = 4'h0;
  logic [31:0] dataBusOut;
  logic        irq;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  logic done = 1'b0;

  key_event_fifo dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .memAddr(memAddr),
    .dataBusIn(dataBusIn), .key(key), .dataBusOut(dataBusOut), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] expData,
                    input logic expIrq, input string name);
    exp_t e;
    e.name = name; e.data = expData; e.irq = expIrq;
    sbq.push_back(e);
    re = 1'b1; memAddr = addr;
    idle(1);
    re = 1'b0; memAddr = 32'h0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1; memAddr = addr; dataBusIn = data;
    idle(1);
    we = 1'b0; memAddr = 32'h0; dataBusIn = 32'h0;
  endtask

  task automatic setKeyWait(input logic [3:0] v);
    key = v;
    idle(3);
  endtask

  // Monitor: compares each presented read against the scoreboard head.
  always @(negedge clk) begin
    if (re && !we) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_read: got %h, no expected entry", dataBusOut);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        tests++;
        if (dataBusOut !== e.data) begin
          fails++;
          $display("FAIL %s data: got %h required %h", e.name, dataBusOut, e.data);
        end
        tests++;
        if (irq !== e.irq) begin
          fails++;
          $display("FAIL %s irq: got %b required %b", e.name, irq, e.irq);
        end
      end
    end
    if (done) begin
      tests++;
      if (sbq.size() != 0) begin
        fails++;
        $display("FAIL scoreboard_drain: got %0d entries left required 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset state
    idle(2);
    rd(A_CTRL, 32'h0, 1'b0, "t1_ctrl_in_reset");
    reset = 1'b1;
    idle(1);
    rd(A_CTRL, 32'h0, 1'b0, "t1_ctrl");
    rd(A_MASK, 32'hF, 1'b0, "t1_mask");
    rd(A_DATA, 32'h0, 1'b0, "t1_data_empty");
    rd(A_CTRL, 32'h0, 1'b0, "t1_ctrl_after_empty_read");

    // 2: single event latency, pop, write to DATA ignored
    key = 4'h1;
    idle(2);
    rd(A_CTRL, 32'h0, 1'b0, "t2_ctrl_before_3rd_edge");
    rd(A_CTRL, 32'h0001_0001, 1'b0, "t2_ctrl_after_3rd_edge");
    rd(A_DATA, 32'h1, 1'b0, "t2_data");
    rd(A_CTRL, 32'h0, 1'b0, "t2_ctrl_after_pop");
    wr(A_DATA, 32'hF);
    rd(A_CTRL, 32'h0, 1'b0, "t2_data_write_ignored");

    // 3: overflow with interrupts enabled
    wr(A_CTRL, 32'h100);
    for (int i = 2; i <= 10; i++) setKeyWait(4'(i));
    rd(A_CTRL, 32'h0008_0105, 1'b1, "t3_ctrl_full_overrun");
    for (int i = 2; i <= 9; i++) rd(A_DATA, 32'(i), 1'b1, $sformatf("t3_data_%0d", i));
    rd(A_CTRL, 32'h0000_0104, 1'b1, "t3_ctrl_drained");
    wr(A_CTRL, 32'h100);
    rd(A_CTRL, 32'h0000_0100, 1'b0, "t3_ctrl_overrun_cleared");

    // 4: push coincident with pop while full
    for (int i = 1; i <= 8; i++) setKeyWait(4'(i));
    key = 4'hB;
    idle(2);
    rd(A_DATA, 32'h1, 1'b1, "t4_data_oldest");
    rd(A_CTRL, 32'h0008_0101, 1'b1, "t4_ctrl_still_full");
    for (int i = 2; i <= 8; i++) rd(A_DATA, 32'(i), 1'b1, $sformatf("t4_data_%0d", i));
    rd(A_DATA, 32'hB, 1'b1, "t4_data_new");
    rd(A_CTRL, 32'h0000_0100, 1'b0, "t4_ctrl_empty");

    // 5: mask
    wr(A_MASK, 32'h2);
    rd(A_MASK, 32'h2, 1'b0, "t5_mask");
    setKeyWait(4'hA);
    rd(A_CTRL, 32'h0000_0100, 1'b0, "t5_masked_no_event");
    setKeyWait(4'h8);
    rd(A_CTRL, 32'h0001_0101, 1'b1, "t5_ctrl_one_event");
    rd(A_DATA, 32'h8, 1'b1, "t5_data_snapshot");
    wr(A_MASK, 32'hF);

    // 6: async reset mid-stream
    for (int i = 0; i <= 7; i++) setKeyWait(4'(i));
    setKeyWait(4'h9);
    for (int i = 0; i <= 2; i++) rd(A_DATA, 32'(i), 1'b1, $sformatf("t6_data_%0d", i));
    rd(A_CTRL, 32'h0005_0105, 1'b1, "t6_ctrl_before_reset");
    #2;
    reset = 1'b0;
    key = 4'h0;
    #1;
    re = 1'b1; memAddr = A_CTRL;
    sbq.push_back('{name: "t6_in_reset", data: 32'h0, irq: 1'b0});
    idle(1);
    re = 1'b0; memAddr = 32'h0;
    idle(2);
    reset = 1'b1;
    idle(1);
    rd(A_CTRL, 32'h0, 1'b0, "t6_ctrl_after_reset");
    rd(A_MASK, 32'hF, 1'b0, "t6_mask_after_reset");
    setKeyWait(4'h5);
    rd(A_CTRL, 32'h0001_0001, 1'b0, "t6_ctrl_fresh_event");
    rd(A_DATA, 32'h5, 1'b0, "t6_data_fresh_event");

    idle(2);
    done = 1'b1;
  end

endmodule
